pe_r_horner: RTL and testbench

PE_R_HORNER -- requirements
Module: pe_r_horner

---
 rtl/pe_pkg.sv | 10 +
 rtl/pe_sat.sv | 18 +
 rtl/pe_r_horner.sv | 118 +++++++++++
 tb/tb_pe_r_horner.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared mode/state enums and default Q-format bounds for the Horner PE.
package pe_pkg;
  localparam int DEF_INT_BW = 5;
  localparam int DEF_FRA_BW = 7;
  localparam int OP_BW = DEF_INT_BW + DEF_FRA_BW;
  localparam int OP_MAX = (1 << OP_BW) - 1;
  localparam int OP_MIN = -(1 << OP_BW);
  typedef enum logic [1:0] {MODE_GEMM, MODE_DIV, MODE_EXP, MODE_LOG} mode_e;
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;
endpackage

// File: rtl/pe_sat.sv
// pe_sat: arithmetic shift right by SH (floor) then clamp to [-2^LIM, 2^LIM-1].
module pe_sat #(
  parameter int IN_W = 16,
  parameter int OUT_W = 16,
  parameter int SH = 0,
  parameter int LIM = pe_pkg::OP_BW
) (
  input  logic signed [IN_W-1:0]  d_i,
  output logic signed [OUT_W-1:0] q_o
);
  localparam logic signed [IN_W-1:0] HI = {{(IN_W-LIM){1'b0}}, {LIM{1'b1}}};
  localparam logic signed [IN_W-1:0] LO = ~HI;
  logic signed [IN_W-1:0] s;
  always_comb begin
    s = d_i >>> SH;
    q_o = s > HI ? HI[OUT_W-1:0] : s < LO ? LO[OUT_W-1:0] : s[OUT_W-1:0];
  end
endmodule

// File: rtl/pe_r_horner.sv
// pe_r_horner: systolic PE doing one-cycle gemm MAC or Horner polynomial evaluation.
module pe_r_horner
  import pe_pkg::*;
#(
  parameter int INT_BW = DEF_INT_BW,
  parameter int FRA_BW = DEF_FRA_BW,
  parameter int MUL_BW = 16,
  parameter int ACC_BW = 32,
  parameter int DEG_MAX = 7,
  parameter int DEG_W = $clog2(DEG_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mode_i,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [MUL_BW-1:0] x_i,
  input  logic signed [MUL_BW-1:0] wc_i,
  input  logic signed [ACC_BW-1:0] o_i,
  input  logic [DEG_W-1:0]         deg_i,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  input  logic signed [MUL_BW-1:0] coef_i,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_BW-1:0] o_o,
  output logic signed [MUL_BW-1:0] wc_o,
  output logic                     busy
);
  localparam int LIM = INT_BW + FRA_BW;
  state_e state_q, state_d;
  mode_e mode_q, mode_d;
  logic signed [ACC_BW-1:0] acc_q, acc_d, o_q, o_d, prod, sum;
  logic signed [MUL_BW-1:0] x_q, x_d, wc_q, wc_d, x_c, w_c, c_c, a_c, ma, mb;
  logic [DEG_W-1:0] cnt_q, cnt_d;
  logic ov_q, ov_d, iter, in_fire, coef_fire;
  function automatic logic signed [ACC_BW-1:0] sx(input logic signed [MUL_BW-1:0] v);
    return {{(ACC_BW-MUL_BW){v[MUL_BW-1]}}, v};
  endfunction
  pe_sat #(.IN_W(MUL_BW), .OUT_W(MUL_BW), .SH(0), .LIM(LIM)) u_sat_x (.d_i(x_i), .q_o(x_c));
  pe_sat #(.IN_W(MUL_BW), .OUT_W(MUL_BW), .SH(0), .LIM(LIM)) u_sat_w (.d_i(wc_i), .q_o(w_c));
  pe_sat #(.IN_W(MUL_BW), .OUT_W(MUL_BW), .SH(0), .LIM(LIM)) u_sat_c (.d_i(coef_i), .q_o(c_c));
  pe_sat #(.IN_W(ACC_BW), .OUT_W(MUL_BW), .SH(FRA_BW), .LIM(LIM)) u_sat_a (.d_i(acc_q), .q_o(a_c));
  // one shared multiplier: weight*x for gemm, conv(acc)*x during Horner steps
  always_comb begin
    iter = state_q == S_ITER;
    in_ready = state_q == S_IDLE && (!ov_q || out_ready);
    in_fire = in_valid && in_ready;
    coef_fire = coef_valid && iter;
    ma = iter ? a_c : w_c;
    mb = iter ? x_q : x_c;
    prod = sx(ma) * sx(mb);
    sum = prod + (iter ? sx(c_c) <<< FRA_BW : o_i);
    state_d = state_q;
    mode_d = mode_q;
    acc_d = acc_q;
    o_d = o_q;
    x_d = x_q;
    wc_d = wc_q;
    cnt_d = cnt_q;
    ov_d = ov_q;
    if (in_fire) begin
      wc_d = wc_i;
      mode_d = mode_e'(mode_i);
      if (mode_i == MODE_GEMM) begin
        o_d = sum;
        ov_d = 1'b1;
      end else begin
        x_d = x_c;
        cnt_d = deg_i;
        acc_d = '0;
        ov_d = 1'b0;
        state_d = S_ITER;
      end
    end else if (state_q == S_IDLE && out_ready) begin
      ov_d = 1'b0;
    end
    if (coef_fire) begin
      acc_d = sum;
      cnt_d = cnt_q - DEG_W'(1);
      if (cnt_q == '0) begin
        o_d = sum;
        ov_d = 1'b1;
        state_d = S_DONE;
      end
    end
    if (state_q == S_DONE && out_ready) begin
      ov_d = 1'b0;
      state_d = S_IDLE;
    end
    coef_ready = iter;
    busy = state_q != S_IDLE;
    out_valid = ov_q;
    o_o = o_q;
    wc_o = wc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q <= MODE_GEMM;
      acc_q <= '0;
      o_q <= '0;
      x_q <= '0;
      wc_q <= '0;
      cnt_q <= '0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      acc_q <= acc_d;
      o_q <= o_d;
      x_q <= x_d;
      wc_q <= wc_d;
      cnt_q <= cnt_d;
      ov_q <= ov_d;
    end
  end
endmodule

// File: tb/tb_pe_r_horner.sv
// tb_pe_r_horner: directed table, corner sequences and randomized runs against a Horner model.
module tb_pe_r_horner;
  import pe_pkg::*;
  typedef struct packed {
    logic kind;
    logic [15:0] x;
    logic [15:0] wc;
    logic [31:0] o;
    logic [2:0] deg;
    logic [7:0][15:0] c;
    logic gap;
    logic [31:0] e;
  } vec_t;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, coef_valid, coef_ready, out_valid, out_ready, busy;
  logic [1:0] mode_i;
  logic [15:0] x_i, wc_i, coef_i, wc_o;
  logic [31:0] o_i, o_o;
  logic [2:0] deg_i;
  int n_vec = 0, n_err = 0;
  vec_t tbl[8];

  pe_r_horner dut (
    .clk(clk), .rst(rst), .mode_i(mode_i), .in_valid(in_valid), .in_ready(in_ready),
    .x_i(x_i), .wc_i(wc_i), .o_i(o_i), .deg_i(deg_i), .coef_valid(coef_valid),
    .coef_ready(coef_ready), .coef_i(coef_i), .out_valid(out_valid), .out_ready(out_ready),
    .o_o(o_o), .wc_o(wc_o), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic signed [63:0] act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint clampv(input longint v);
    return v > OP_MAX ? longint'(OP_MAX) : (v < OP_MIN ? longint'(OP_MIN) : v);
  endfunction

  function automatic longint conv(input longint a);
    longint s = longint'(1) << DEF_FRA_BW;
    return clampv(a >= 0 ? a / s : -((-a + s - 1) / s));
  endfunction

  function automatic int horner(input longint x, input int deg, input logic [7:0][15:0] c);
    longint acc = 0;
    longint xc = clampv(x);
    for (int i = 0; i <= deg; i++) begin
      acc = conv(acc) * xc + clampv(longint'($signed(c[i]))) * (longint'(1) << DEF_FRA_BW);
      acc = longint'(int'(acc));
    end
    return int'(acc);
  endfunction

  function automatic int gemm_ref(input longint wc, input longint x, input longint o);
    return int'(clampv(wc) * clampv(x) + o);
  endfunction

  function automatic vec_t mk(input bit kind, input int x, input int wc, input int o, input int deg,
                              input int c0, input int c1, input int c2, input bit gap, input int e);
    vec_t v = '0;
    v.kind = kind;
    v.x = 16'(x);
    v.wc = 16'(wc);
    v.o = o;
    v.deg = 3'(deg);
    v.c[0] = 16'(c0);
    v.c[1] = 16'(c1);
    v.c[2] = 16'(c2);
    v.gap = gap;
    v.e = e;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input string nm);
    int t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    chk({nm, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic gemm_run(input string nm, input shortint wc, input shortint x, input int o, input int hold);
    int e = gemm_ref(wc, x, o);
    out_ready = 1'b1;
    mode_i = MODE_GEMM;
    wc_i = wc;
    x_i = x;
    o_i = o;
    in_valid = 1'b1;
    accept(nm);
    out_ready = 1'b0;
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_o"}, $signed(o_o), e);
    chk({nm, "_wc"}, $signed(wc_o), wc);
    repeat (hold) begin
      tick();
      chk({nm, "_hold_valid"}, out_valid, 1);
      chk({nm, "_hold_o"}, $signed(o_o), e);
      chk({nm, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk({nm, "_drain"}, out_valid, 0);
    out_ready = 1'b0;
  endtask

  task automatic poly_run(input string nm, input shortint x, input int deg, input logic [7:0][15:0] c,
                          input bit gap, input int hold, input int e);
    shortint wc = shortint'($urandom);
    out_ready = 1'b0;
    mode_i = 2'($urandom_range(1, 3));
    x_i = x;
    deg_i = 3'(deg);
    wc_i = wc;
    in_valid = 1'b1;
    accept(nm);
    chk({nm, "_busy"}, busy, 1);
    chk({nm, "_coef_ready"}, coef_ready, 1);
    chk({nm, "_wc"}, $signed(wc_o), wc);
    for (int i = 0; i <= deg; i++) begin
      coef_valid = 1'b1;
      coef_i = c[i];
      tick();
      coef_valid = 1'b0;
      coef_i = 16'($urandom);
      if (i < deg) begin
        chk({nm, "_early_valid"}, out_valid, 0);
        if (gap) begin
          tick();
          chk({nm, "_gap_ready"}, coef_ready, 1);
        end
      end
    end
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_o"}, $signed(o_o), e);
    repeat (hold) begin
      tick();
      chk({nm, "_hold_o"}, $signed(o_o), e);
      chk({nm, "_hold_in_ready"}, in_ready, 0);
      chk({nm, "_hold_coef_ready"}, coef_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk({nm, "_drain"}, out_valid, 0);
    chk({nm, "_idle"}, busy, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0][15:0] c;
    tbl[0] = mk(0, 192, 256, 100, 0, 0, 0, 0, 0, 49252);
    tbl[1] = mk(0, -5000, -8000, -1, 0, 0, 0, 0, 0, 16777215);
    tbl[2] = mk(0, 500, -300, 7, 0, 0, 0, 0, 0, -149993);
    tbl[3] = mk(1, 128, 0, 0, 2, 128, 256, 384, 0, 98304);
    tbl[4] = mk(1, 5000, 0, 0, 2, 4095, 4095, 4095, 0, 17293185);
    tbl[5] = mk(1, 128, 0, 0, 2, 128, 256, 384, 1, 98304);
    tbl[6] = mk(1, 300, 0, 0, 0, -200, 0, 0, 0, -25600);
    tbl[7] = mk(1, 64, 0, 0, 2, -1, 0, 0, 0, -64);
    rst = 1'b1;
    {mode_i, in_valid, x_i, wc_i, o_i, deg_i, coef_valid, coef_i, out_ready} = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_o", $signed(o_o), 0);
    chk("rst_wc", $signed(wc_o), 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_coef_ready", coef_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    coef_valid = 1'b1;
    coef_i = 16'd999;
    tick();
    chk("idle_coef_ready", coef_ready, 0);
    chk("idle_coef_busy", busy, 0);
    coef_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].kind == 1'b0)
        gemm_run($sformatf("tbl%0d", i), shortint'(tbl[i].wc), shortint'(tbl[i].x), int'(tbl[i].o), 0);
      else
        poly_run($sformatf("tbl%0d", i), shortint'(tbl[i].x), int'(tbl[i].deg), tbl[i].c,
                 tbl[i].gap, 0, int'(tbl[i].e));
    end
    gemm_run("gemm_bp", 100, 200, 5, 3);
    c = '0;
    c[0] = 16'd128;
    c[1] = 16'd256;
    c[2] = 16'd384;
    poly_run("poly_bp", 128, 2, c, 0, 5, 98304);
    out_ready = 1'b0;
    mode_i = MODE_EXP;
    x_i = 16'd128;
    deg_i = 3'd2;
    wc_i = 16'd77;
    in_valid = 1'b1;
    accept("rst_mid");
    coef_valid = 1'b1;
    coef_i = 16'd128;
    tick();
    coef_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_o", $signed(o_o), 0);
    chk("rst_mid_wc", $signed(wc_o), 0);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_coef_ready", coef_ready, 0);
    poly_run("after_rst", 128, 2, c, 0, 0, 98304);
    for (int i = 0; i < 40; i++) begin
      shortint w = shortint'($urandom);
      shortint x = shortint'($urandom);
      int o = int'($urandom);
      gemm_run($sformatf("rnd_gemm%0d", i), w, x, o, int'($urandom_range(0, 2)));
    end
    for (int i = 0; i < 30; i++) begin
      shortint x = shortint'($urandom);
      int d = int'($urandom_range(0, 7));
      for (int k = 0; k < 8; k++) c[k] = 16'($urandom);
      poly_run($sformatf("rnd_poly%0d", i), x, d, c, 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)), horner(longint'(x), d, c));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
